// File: rtl/sha256_arbiter.sv
// Round-robin arbiter that lends a single SHA-256 core to NUM_REQ message sources,
// one whole message at a time, and hands the captured digest back to the owner.
module sha256_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [64*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_last,
  input  logic [6*NUM_REQ-1:0]  req_invalid_bits,
  input  logic [NUM_REQ-1:0]    req_ready_send,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    res_valid,
  input  logic [NUM_REQ-1:0]    res_ready,
  output logic [255:0]          res_hash,
  output logic                  res_timeout,
  output logic [63:0]           core_data_in,
  output logic                  core_data_valid,
  output logic                  core_ready_send,
  output logic                  core_last_block,
  output logic [5:0]            core_invalid_bits,
  input  logic                  core_ready_rcv,
  input  logic                  core_hash_valid,
  input  logic [255:0]          core_hash_value,
  output logic                  busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, FEED, WAIT_HASH, DELIVER} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   rr_next;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] grant_q;
  logic [15:0]        wait_cnt;
  logic               accept_last;
  logic               timed_out;
  int                 cand;

  // First requesting index at or after the round-robin pointer, wrapping once.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign accept_last = (state == FEED) && req_valid[owner] && core_ready_rcv && req_last[owner];
  assign timed_out   = (wait_cnt == 16'(TIMEOUT - 1));
  assign rr_next     = (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (pick_found) state_next = FEED;
      FEED:      if (accept_last) state_next = WAIT_HASH;
      WAIT_HASH: if (core_hash_valid || timed_out) state_next = DELIVER;
      DELIVER:   if (res_ready[owner]) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Ownership, round-robin pointer, hash-wait counter and the captured result.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      owner       <= '0;
      grant_q     <= '0;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      res_hash    <= '0;
      res_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner   <= pick_idx;
            grant_q <= NUM_REQ'(1) << pick_idx;
          end
        end
        FEED: begin
          if (accept_last) wait_cnt <= '0;
        end
        WAIT_HASH: begin
          if (core_hash_valid) begin
            res_hash    <= core_hash_value;
            res_timeout <= 1'b0;
          end else if (timed_out) begin
            res_hash    <= '0;
            res_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DELIVER: begin
          if (res_ready[owner]) begin
            grant_q <= '0;
            rr_ptr  <= rr_next;
          end
        end
        default: ;
      endcase
    end
  end

  // Only the owner's stream reaches the core; everything is zero outside a message.
  always_comb begin
    core_data_in      = '0;
    core_data_valid   = 1'b0;
    core_ready_send   = 1'b0;
    core_last_block   = 1'b0;
    core_invalid_bits = '0;
    req_ready         = '0;
    res_valid         = '0;
    case (state)
      FEED: begin
        core_data_in      = req_data[64*owner +: 64];
        core_data_valid   = req_valid[owner];
        core_ready_send   = req_ready_send[owner];
        core_last_block   = req_last[owner];
        core_invalid_bits = req_invalid_bits[6*owner +: 6];
        req_ready         = grant_q & {NUM_REQ{core_ready_rcv}};
      end
      WAIT_HASH: core_ready_send = req_ready_send[owner];
      DELIVER:   res_valid = grant_q;
      default: ;
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_sha256_arbiter.sv
// Self-checking bench for sha256_arbiter: plays requesters and core, predicts the
// owner sequence from the round-robin rule and checks the muxed stream and results.
module tb_sha256_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 16;

  logic                  clk = 1'b0;
  logic                  n_rst = 1'b0;
  logic [NUM_REQ-1:0]    req = '0;
  logic [64*NUM_REQ-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_last = '0;
  logic [6*NUM_REQ-1:0]  req_invalid_bits = '0;
  logic [NUM_REQ-1:0]    req_ready_send = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    res_valid;
  logic [NUM_REQ-1:0]    res_ready = '0;
  logic [255:0]          res_hash;
  logic                  res_timeout;
  logic [63:0]           core_data_in;
  logic                  core_data_valid;
  logic                  core_ready_send;
  logic                  core_last_block;
  logic [5:0]            core_invalid_bits;
  logic                  core_ready_rcv = 1'b0;
  logic                  core_hash_valid = 1'b0;
  logic [255:0]          core_hash_value = '0;
  logic                  busy;

  int          vectors = 0;
  int          miscompares = 0;
  int          model_rr = 0;
  logic [63:0] msg_words [8];
  logic [5:0]  msg_inv;

  sha256_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_invalid_bits(req_invalid_bits), .req_ready_send(req_ready_send),
    .req_ready(req_ready), .grant(grant), .res_valid(res_valid), .res_ready(res_ready),
    .res_hash(res_hash), .res_timeout(res_timeout), .core_data_in(core_data_in),
    .core_data_valid(core_data_valid), .core_ready_send(core_ready_send),
    .core_last_block(core_last_block), .core_invalid_bits(core_invalid_bits),
    .core_ready_rcv(core_ready_rcv), .core_hash_valid(core_hash_valid),
    .core_hash_value(core_hash_value), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic clear_inputs();
    req = '0; req_data = '0; req_valid = '0; req_last = '0; req_invalid_bits = '0;
    req_ready_send = '0; res_ready = '0; core_ready_rcv = 1'b0;
    core_hash_valid = 1'b0; core_hash_value = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    n_rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    model_rr = 0;
  endtask

  // Serves the message the round-robin rule says comes next; starts and ends at a negedge in IDLE.
  task automatic serve_message(input int nwords, input int stall_first, input bit do_timeout,
                               input int hash_delay, input int res_stall, input bit drop_in_feed,
                               input bit keep_req);
    int exp_owner, c, lat, w, guard, cnt;
    logic rdy, exp_to;
    logic [NUM_REQ-1:0] oh;
    logic [255:0] h, exp_hash;
    exp_owner = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = (model_rr + k) % NUM_REQ;
      if (req[c]) exp_owner = c;
    end
    oh = NUM_REQ'(1) << exp_owner;

    vectors++;
    if (grant !== '0) begin miscompares++; $display("FAIL grant_before: got %b expected 0", grant); end
    lat = 0;
    while (grant === '0 && lat < 8) begin @(posedge clk); @(negedge clk); lat++; end
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL grant_latency: got %0d cycles expected 1", lat); end
    vectors++;
    if (grant !== oh) begin miscompares++; $display("FAIL grant_owner: got %b expected %b", grant, oh); end

    w = 0; guard = 0;
    while (w < nwords && guard < 200) begin
      for (int k = 0; k < 2 * NUM_REQ; k++) req_data[32*k +: 32] = $urandom;
      req_data[64*exp_owner +: 64] = msg_words[w];
      req_valid = NUM_REQ'($urandom); req_valid[exp_owner] = 1'b1;
      req_last = NUM_REQ'($urandom); req_last[exp_owner] = (w == nwords - 1);
      req_invalid_bits = (6*NUM_REQ)'($urandom); req_invalid_bits[6*exp_owner +: 6] = msg_inv;
      req_ready_send = NUM_REQ'($urandom);
      rdy = (guard < stall_first) ? 1'b0 : ($urandom_range(0, 3) != 0);
      core_ready_rcv = rdy;
      if (drop_in_feed && w > 0) req[exp_owner] = 1'b0;
      #1;
      vectors++;
      if (core_data_valid !== 1'b1) begin miscompares++; $display("FAIL feed_valid: got %b expected 1 word %0d", core_data_valid, w); end
      vectors++;
      if (core_data_in !== msg_words[w]) begin miscompares++; $display("FAIL feed_data: got %h expected %h", core_data_in, msg_words[w]); end
      vectors++;
      if (core_last_block !== (w == nwords - 1)) begin miscompares++; $display("FAIL feed_last: got %b word %0d of %0d", core_last_block, w, nwords); end
      vectors++;
      if (core_invalid_bits !== msg_inv) begin miscompares++; $display("FAIL feed_inv: got %0d expected %0d", core_invalid_bits, msg_inv); end
      vectors++;
      if (core_ready_send !== req_ready_send[exp_owner]) begin miscompares++; $display("FAIL feed_ready_send: got %b expected %b", core_ready_send, req_ready_send[exp_owner]); end
      vectors++;
      if (req_ready !== (rdy ? oh : NUM_REQ'(0))) begin miscompares++; $display("FAIL feed_req_ready: got %b expected %b", req_ready, rdy ? oh : NUM_REQ'(0)); end
      vectors++;
      if (grant !== oh) begin miscompares++; $display("FAIL feed_grant: got %b expected %b", grant, oh); end
      @(posedge clk); @(negedge clk);
      if (rdy) w++;
      guard++;
    end

    req_valid[exp_owner] = 1'b1;
    core_ready_rcv = 1'b1;
    core_hash_valid = 1'b0;
    core_hash_value = rand256();
    #1;
    vectors++;
    if (core_data_valid !== 1'b0) begin miscompares++; $display("FAIL wait_valid_forced: got %b expected 0", core_data_valid); end
    vectors++;
    if (core_ready_send !== req_ready_send[exp_owner]) begin miscompares++; $display("FAIL wait_ready_send: got %b expected %b", core_ready_send, req_ready_send[exp_owner]); end
    vectors++;
    if (busy !== 1'b1 || res_valid !== '0) begin miscompares++; $display("FAIL wait_state: busy %b res_valid %b expected 1/0", busy, res_valid); end
    req_valid = '0;
    core_ready_rcv = 1'b0;

    h = rand256();
    if (do_timeout) begin
      cnt = 0;
      while (res_valid === '0 && cnt < 40) begin @(posedge clk); @(negedge clk); cnt++; end
      vectors++;
      if (cnt !== TIMEOUT) begin miscompares++; $display("FAIL timeout_cycles: got %0d expected %0d", cnt, TIMEOUT); end
      exp_hash = '0; exp_to = 1'b1;
    end else begin
      for (int d = 0; d < hash_delay; d++) begin
        core_hash_value = rand256();
        @(posedge clk); @(negedge clk);
      end
      vectors++;
      if (res_valid !== '0) begin miscompares++; $display("FAIL early_result: got %b expected 0", res_valid); end
      core_hash_valid = 1'b1; core_hash_value = h;
      @(posedge clk); @(negedge clk);
      core_hash_valid = 1'b0;
      exp_hash = h; exp_to = 1'b0;
    end
    vectors++;
    if (res_valid !== oh) begin miscompares++; $display("FAIL res_valid: got %b expected %b", res_valid, oh); end
    vectors++;
    if (res_hash !== exp_hash) begin miscompares++; $display("FAIL res_hash: got %h expected %h", res_hash, exp_hash); end
    vectors++;
    if (res_timeout !== exp_to) begin miscompares++; $display("FAIL res_timeout: got %b expected %b", res_timeout, exp_to); end

    for (int s = 0; s < res_stall; s++) begin
      res_ready = ~oh;
      core_hash_valid = 1'($urandom);
      core_hash_value = ~exp_hash;
      @(posedge clk); @(negedge clk);
      vectors++;
      if (res_valid !== oh) begin miscompares++; $display("FAIL stall_valid: got %b expected %b", res_valid, oh); end
      vectors++;
      if (res_hash !== exp_hash) begin miscompares++; $display("FAIL stall_hash: got %h expected %h", res_hash, exp_hash); end
    end
    core_hash_valid = 1'b0;
    res_ready = oh;
    @(posedge clk); @(negedge clk);
    res_ready = '0;
    req[exp_owner] = keep_req;
    vectors++;
    if (res_valid !== '0 || grant !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL release: res_valid %b grant %b busy %b expected all 0", res_valid, grant, busy);
    end
    model_rr = (exp_owner + 1) % NUM_REQ;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    vectors++;
    if (grant !== '0 || res_valid !== '0 || busy !== 1'b0 || req_ready !== '0) begin
      miscompares++; $display("FAIL reset_ctrl: grant %b res_valid %b busy %b req_ready %b expected 0", grant, res_valid, busy, req_ready);
    end
    vectors++;
    if (res_hash !== '0 || res_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_result: hash %h timeout %b expected 0", res_hash, res_timeout); end
    vectors++;
    if (core_data_in !== '0 || core_data_valid !== 1'b0 || core_ready_send !== 1'b0 ||
        core_last_block !== 1'b0 || core_invalid_bits !== '0) begin
      miscompares++; $display("FAIL reset_core: data %h valid %b rs %b last %b inv %0d expected 0",
                               core_data_in, core_data_valid, core_ready_send, core_last_block, core_invalid_bits);
    end
  endtask

  task automatic test_single();
    msg_words[0] = 64'h0123456789ABCDEF;
    msg_words[1] = 64'h0123456789ABCDEF;
    msg_inv = 6'd8;
    req = 2'b01;
    serve_message(2, 0, 1'b0, 3, 0, 1'b0, 1'b0);
    req = 2'b11;
    for (int k = 0; k < 8; k++) msg_words[k] = {$urandom, $urandom};
    serve_message(1, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    req = '0;
  endtask

  task automatic test_contention();
    apply_reset();
    req = 2'b11;
    for (int m = 0; m < 4; m++) begin
      for (int k = 0; k < 8; k++) msg_words[k] = {$urandom, $urandom};
      msg_inv = 6'($urandom);
      serve_message(3, 0, 1'b0, $urandom_range(0, 4), 0, 1'b0, 1'b1);
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 8; k++) msg_words[k] = {$urandom, $urandom};
    msg_inv = 6'($urandom);
    req = 2'b10;
    serve_message(3, 5, 1'b0, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 8; k++) msg_words[k] = {$urandom, $urandom};
    msg_inv = 6'($urandom);
    req = 2'b01;
    serve_message(2, 0, 1'b1, 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_late_hash();
    for (int k = 0; k < 8; k++) msg_words[k] = {$urandom, $urandom};
    msg_inv = 6'($urandom);
    req = 2'b11;
    serve_message(2, 0, 1'b0, TIMEOUT - 1, 10, 1'b1, 1'b0);
    req = '0;
  endtask

  task automatic test_reset_mid_feed();
    for (int k = 0; k < 8; k++) msg_words[k] = {$urandom, $urandom};
    msg_inv = 6'($urandom);
    req = 2'b01;
    serve_message(1, 0, 1'b0, 1, 0, 1'b0, 1'b0);
    req = 2'b10;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (grant !== 2'b10) begin miscompares++; $display("FAIL midrst_grant: got %b expected 10", grant); end
    req_valid = 2'b10; req_data[64 +: 64] = msg_words[0]; core_ready_rcv = 1'b1;
    @(posedge clk); @(negedge clk);
    req_data[64 +: 64] = msg_words[1]; core_ready_rcv = 1'b0;
    n_rst = 1'b0;
    #1;
    vectors++;
    if (grant !== '0 || core_data_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      miscompares++; $display("FAIL midrst_state: grant %b valid %b busy %b req_ready %b expected 0", grant, core_data_valid, busy, req_ready);
    end
    @(negedge clk);
    clear_inputs();
    n_rst = 1'b1;
    model_rr = 0;
    req = 2'b11;
    serve_message(2, 0, 1'b0, 1, 0, 1'b0, 1'b0);
    req = '0;
  endtask

  task automatic test_random();
    for (int m = 0; m < 12; m++) begin
      for (int k = 0; k < 8; k++) msg_words[k] = {$urandom, $urandom};
      msg_inv = 6'($urandom);
      req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      serve_message($urandom_range(1, 4), $urandom_range(0, 2), ($urandom_range(0, 5) == 0),
                    $urandom_range(0, TIMEOUT - 1), $urandom_range(0, 3), 1'($urandom), 1'b0);
    end
    req = '0;
  endtask

  initial begin
    $display("[TB] sha256_arbiter bench start");
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_timeout();
    test_late_hash();
    test_reset_mid_feed();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
